multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//   Parametrised multicycle MIPS control FSM; successor to the 5-state add/addi/ori/beq/j unit.
//   Adds full R-type ALU ops, andi, lw/sw with memory wait states, bne, a fetch/memory timeout,
//   and an illegal-opcode trap. Drives the shared-memory multicycle datapath (PC, IR, regfile, ALU).
// PARAMETERS
//   ALUC_W      3    ALU_Control width (>=3); codes below zero-extended to ALUC_W
//   MEM_WAIT    1    1: memory states wait for mem_ready; 0: mem_ready ignored, treated as 1
//   WAIT_MAX    15   max wait cycles in a memory state before bus error (counter width $clog2(WAIT_MAX+1))
//   TRAP_ILL    1    1: illegal opcode/bus error -> TRAP (held until rst); 0: flag, return to FETCH
// PORTS
//   clk           in   1       rising-edge clock
//   rst           in   1       synchronous, active-high reset
//   Op            in   6       IR[31:26]; stable from DECODE until next FETCH
//   Funct         in   6       IR[5:0]
//   mem_ready     in   1       memory completes the current access this cycle
//   IorD, Mem_Write, IR_Write, PC_Write, Branch, Branch_NE, ALU_SrcA, Reg_Write, Mem_Reg,
//   Reg_Dst, en_zero_sign  out 1  datapath controls (Branch_NE: PC loads when !zero)
//   PC_Src        out  2       00 ALU result, 01 ALUOut, 10 jump target
//   ALU_SrcB      out  2       00 reg B, 01 const 4, 10 imm ext, 11 imm ext<<2
//   ALU_Control   out  ALUC_W  0 NOP, 1 ADD, 2 AND, 3 OR, 4 SUB, 5 SLT
//   illegal_op    out  1       sticky: unsupported Op/Funct decoded
//   bus_err       out  1       sticky: wait exceeded WAIT_MAX
//   state_dbg     out  4       current state encoding
// BEHAVIOUR
//   - Outputs are Moore decodes of state (plus Op/Funct, and mem_ready in memory states).
//   - Reset: state=FETCH, wait counter=0, illegal_op=0, bus_err=0; all controls 0 while rst=1.
//   - States: FETCH(0) DECODE(1) EXEC_R(2) EXEC_I(3) ALU_WB(4) BRANCH(5) JUMP(6)
//     MEM_ADDR(7) MEM_RD(8) MEM_WB(9) MEM_WR(10) TRAP(15).
//   - FETCH: IorD=0, ALU_SrcA=0, ALU_SrcB=01, ADD, PC_Src=00; IR_Write=PC_Write=1 only in the
//     cycle mem_ready=1, then -> DECODE; else stay, counter++.
//   - DECODE: ALU_SrcA=0, ALU_SrcB=11, ADD (branch target to ALUOut). Next by Op:
//     00 -> EXEC_R if Funct in {20 add,22 sub,24 and,25 or,2A slt}; 08/0C/0D -> EXEC_I;
//     04/05 -> BRANCH; 02 -> JUMP; 23/2B -> MEM_ADDR; else set illegal_op, -> TRAP (TRAP_ILL=1) or FETCH.
//   - EXEC_R: SrcA=1, SrcB=00, op from Funct. EXEC_I: SrcA=1, SrcB=10; addi ADD sign-ext,
//     andi AND/ori OR with en_zero_sign=1. Both -> ALU_WB.
//   - ALU_WB: Reg_Write=1, Mem_Reg=0, Reg_Dst=1 for R-type else 0, en_zero_sign held -> FETCH.
//   - BRANCH: SrcA=1, SrcB=00, SUB, PC_Src=01; Branch=1 (beq) or Branch_NE=1 (bne) -> FETCH.
//   - JUMP: PC_Src=10, PC_Write=1 -> FETCH.
//   - MEM_ADDR: SrcA=1, SrcB=10, ADD; -> MEM_RD (lw) / MEM_WR (sw).
//   - MEM_RD: IorD=1; wait for mem_ready -> MEM_WB. MEM_WB: Reg_Write=1, Mem_Reg=1, Reg_Dst=0 -> FETCH.
//   - MEM_WR: IorD=1, Mem_Write=1 held until the cycle mem_ready=1 -> FETCH.
//   - Latency (mem_ready=1): R/I 4 cycles, beq/bne/j 3, sw 4, lw 5.
//   - Wait counter clears on entering any memory state and on completion; if it reaches WAIT_MAX
//     with mem_ready=0: bus_err=1, all writes 0 that cycle, -> TRAP or FETCH per TRAP_ILL.
//   - TRAP: all write enables 0, stays until rst. Flags clear only on rst.
//   - rst mid-instruction: next cycle FETCH, no partial write is issued on the reset cycle.
// TESTING
//   1. add (Op 00, Funct 20), mem_ready=1 -> FETCH,DECODE,EXEC_R,ALU_WB; Reg_Write/Reg_Dst=1 cycle 4 only.
//   2. lw (Op 23), mem_ready low 3 cycles in MEM_RD -> 8 cycles total, one Reg_Write with Mem_Reg=1.
//   3. bne (Op 05) -> 3 cycles, Branch_NE=1, Branch=0, PC_Src=01 in BRANCH; beq sets Branch only.
//   4. Op 3F, TRAP_ILL=1 -> illegal_op=1, state_dbg=15 held 20 cycles, no write enables; rst -> FETCH.
//   5. FETCH with mem_ready=0 for WAIT_MAX(15) cycles -> bus_err=1, IR_Write never asserted.
//   6. rst=1 in MEM_WR with Mem_Write high -> Mem_Write=0 same cycle, state_dbg=0 next cycle.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_fsm
// Purpose  : Control FSM for a shared-memory multicycle MIPS datapath.
//            Supports R-type add/sub/and/or/slt, addi/andi/ori, lw/sw with
//            memory wait states, beq/bne, j, a memory/fetch timeout and an
//            illegal-opcode trap.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   Op           in   IR[31:26], stable from DECODE until the next FETCH
//   Funct        in   IR[5:0]
//   mem_ready    in   memory completes the current access this cycle
//   IorD .. en_zero_sign  out  single-bit datapath controls
//   PC_Src       out  00 ALU result, 01 ALUOut, 10 jump target
//   ALU_SrcB     out  00 reg B, 01 const 4, 10 imm ext, 11 imm ext<<2
//   ALU_Control  out  0 NOP, 1 ADD, 2 AND, 3 OR, 4 SUB, 5 SLT
//   illegal_op   out  sticky: unsupported Op/Funct decoded
//   bus_err      out  sticky: memory wait exceeded WAIT_MAX
//   state_dbg    out  current state encoding
// ============================================================================
module multicycle_ctrl_fsm #(
  parameter int ALUC_W   = 3,
  parameter int MEM_WAIT = 1,
  parameter int WAIT_MAX = 15,
  parameter int TRAP_ILL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        Op,
  input  logic [5:0]        Funct,
  input  logic              mem_ready,
  output logic              IorD,
  output logic              Mem_Write,
  output logic              IR_Write,
  output logic              PC_Write,
  output logic              Branch,
  output logic              Branch_NE,
  output logic              ALU_SrcA,
  output logic              Reg_Write,
  output logic              Mem_Reg,
  output logic              Reg_Dst,
  output logic              en_zero_sign,
  output logic [1:0]        PC_Src,
  output logic [1:0]        ALU_SrcB,
  output logic [ALUC_W-1:0] ALU_Control,
  output logic              illegal_op,
  output logic              bus_err,
  output logic [3:0]        state_dbg
);

  // State encoding
  localparam logic [3:0] c_S_FETCH    = 4'd0;
  localparam logic [3:0] c_S_DECODE   = 4'd1;
  localparam logic [3:0] c_S_EXEC_R   = 4'd2;
  localparam logic [3:0] c_S_EXEC_I   = 4'd3;
  localparam logic [3:0] c_S_ALU_WB   = 4'd4;
  localparam logic [3:0] c_S_BRANCH   = 4'd5;
  localparam logic [3:0] c_S_JUMP     = 4'd6;
  localparam logic [3:0] c_S_MEM_ADDR = 4'd7;
  localparam logic [3:0] c_S_MEM_RD   = 4'd8;
  localparam logic [3:0] c_S_MEM_WB   = 4'd9;
  localparam logic [3:0] c_S_MEM_WR   = 4'd10;
  localparam logic [3:0] c_S_TRAP     = 4'd15;

  // Where an illegal opcode or a bus error sends the machine
  localparam logic [3:0] c_S_ERR = (TRAP_ILL != 0) ? c_S_TRAP : c_S_FETCH;

  // Opcodes
  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_ANDI  = 6'h0C;
  localparam logic [5:0] c_OP_ORI   = 6'h0D;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] c_FN_ADD = 6'h20;
  localparam logic [5:0] c_FN_SUB = 6'h22;
  localparam logic [5:0] c_FN_AND = 6'h24;
  localparam logic [5:0] c_FN_OR  = 6'h25;
  localparam logic [5:0] c_FN_SLT = 6'h2A;

  // ALU control codes, zero-extended to ALUC_W
  localparam logic [ALUC_W-1:0] c_ALU_NOP = ALUC_W'(0);
  localparam logic [ALUC_W-1:0] c_ALU_ADD = ALUC_W'(1);
  localparam logic [ALUC_W-1:0] c_ALU_AND = ALUC_W'(2);
  localparam logic [ALUC_W-1:0] c_ALU_OR  = ALUC_W'(3);
  localparam logic [ALUC_W-1:0] c_ALU_SUB = ALUC_W'(4);
  localparam logic [ALUC_W-1:0] c_ALU_SLT = ALUC_W'(5);

  // Wait counter sizing
  localparam int                 c_CNT_W      = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_WAIT_LIMIT = c_CNT_W'(WAIT_MAX);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

  logic [3:0]         r_state;
  logic [3:0]         w_next_state;
  logic [c_CNT_W-1:0] r_wait_cnt;
  logic               r_illegal;
  logic               r_bus_err;
  logic               w_ready;
  logic               w_in_mem;
  logic               w_timeout;
  logic               w_set_ill;
  logic               w_funct_ok;
  logic [ALUC_W-1:0]  w_funct_alu;
  logic               w_logic_imm;

  // Memory handshake: with MEM_WAIT=0 every access completes immediately
  generate
    if (MEM_WAIT != 0) begin : g_mem_wait
      assign w_ready = mem_ready;
    end else begin : g_no_mem_wait
      assign w_ready = 1'b1;
    end
  endgenerate

  // States that wait on the memory and therefore run the wait counter
  assign w_in_mem  = (r_state == c_S_FETCH) || (r_state == c_S_MEM_RD) ||
                     (r_state == c_S_MEM_WR);
  // Timeout fires in the cycle after WAIT_MAX full wait cycles have elapsed
  assign w_timeout = w_in_mem && !w_ready && (r_wait_cnt == c_WAIT_LIMIT);

  // andi/ori take a zero-extended immediate; addi and lw/sw take sign extension
  assign w_logic_imm = (Op == c_OP_ANDI) || (Op == c_OP_ORI);

  // R-type function decode
  always_comb begin
    w_funct_ok  = 1'b1;
    w_funct_alu = c_ALU_NOP;
    case (Funct)
      c_FN_ADD: w_funct_alu = c_ALU_ADD;
      c_FN_SUB: w_funct_alu = c_ALU_SUB;
      c_FN_AND: w_funct_alu = c_ALU_AND;
      c_FN_OR:  w_funct_alu = c_ALU_OR;
      c_FN_SLT: w_funct_alu = c_ALU_SLT;
      default:  w_funct_ok  = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    w_set_ill    = 1'b0;
    case (r_state)
      c_S_FETCH: begin
        if (w_timeout)    w_next_state = c_S_ERR;
        else if (w_ready) w_next_state = c_S_DECODE;
      end
      c_S_DECODE: begin
        case (Op)
          c_OP_RTYPE: begin
            if (w_funct_ok) begin
              w_next_state = c_S_EXEC_R;
            end else begin
              w_set_ill    = 1'b1;
              w_next_state = c_S_ERR;
            end
          end
          c_OP_ADDI, c_OP_ANDI, c_OP_ORI: w_next_state = c_S_EXEC_I;
          c_OP_BEQ, c_OP_BNE:             w_next_state = c_S_BRANCH;
          c_OP_J:                         w_next_state = c_S_JUMP;
          c_OP_LW, c_OP_SW:               w_next_state = c_S_MEM_ADDR;
          default: begin
            w_set_ill    = 1'b1;
            w_next_state = c_S_ERR;
          end
        endcase
      end
      c_S_EXEC_R, c_S_EXEC_I: w_next_state = c_S_ALU_WB;
      c_S_ALU_WB, c_S_BRANCH, c_S_JUMP, c_S_MEM_WB: w_next_state = c_S_FETCH;
      c_S_MEM_ADDR: w_next_state = (Op == c_OP_LW) ? c_S_MEM_RD : c_S_MEM_WR;
      c_S_MEM_RD: begin
        if (w_timeout)    w_next_state = c_S_ERR;
        else if (w_ready) w_next_state = c_S_MEM_WB;
      end
      c_S_MEM_WR: begin
        if (w_timeout)    w_next_state = c_S_ERR;
        else if (w_ready) w_next_state = c_S_FETCH;
      end
      c_S_TRAP: w_next_state = c_S_TRAP;
      default:  w_next_state = c_S_FETCH;
    endcase
  end

  // State, wait counter and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_S_FETCH;
      r_wait_cnt <= '0;
      r_illegal  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // Counting only while stalled in a memory state; any completion,
      // timeout or transition (including entry) leaves the counter at zero.
      if (w_in_mem && !w_ready && !w_timeout) begin
        r_wait_cnt <= r_wait_cnt + c_CNT_ONE;
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_set_ill) r_illegal <= 1'b1;
      if (w_timeout) r_bus_err <= 1'b1;
    end
  end

  // Output decode; everything is forced low while rst is asserted so that a
  // reset landing mid-instruction issues no partial write.
  always_comb begin
    IorD         = 1'b0;
    Mem_Write    = 1'b0;
    IR_Write     = 1'b0;
    PC_Write     = 1'b0;
    Branch       = 1'b0;
    Branch_NE    = 1'b0;
    ALU_SrcA     = 1'b0;
    Reg_Write    = 1'b0;
    Mem_Reg      = 1'b0;
    Reg_Dst      = 1'b0;
    en_zero_sign = 1'b0;
    PC_Src       = 2'b00;
    ALU_SrcB     = 2'b00;
    ALU_Control  = c_ALU_NOP;
    if (!rst) begin
      case (r_state)
        c_S_FETCH: begin
          ALU_SrcB    = 2'b01;
          ALU_Control = c_ALU_ADD;
          IR_Write    = w_ready;
          PC_Write    = w_ready;
        end
        c_S_DECODE: begin
          ALU_SrcB    = 2'b11;
          ALU_Control = c_ALU_ADD;
        end
        c_S_EXEC_R: begin
          ALU_SrcA    = 1'b1;
          ALU_Control = w_funct_alu;
        end
        c_S_EXEC_I: begin
          ALU_SrcA     = 1'b1;
          ALU_SrcB     = 2'b10;
          en_zero_sign = w_logic_imm;
          if (Op == c_OP_ANDI)     ALU_Control = c_ALU_AND;
          else if (Op == c_OP_ORI) ALU_Control = c_ALU_OR;
          else                     ALU_Control = c_ALU_ADD;
        end
        c_S_ALU_WB: begin
          Reg_Write    = 1'b1;
          Reg_Dst      = (Op == c_OP_RTYPE);
          en_zero_sign = w_logic_imm;
        end
        c_S_BRANCH: begin
          ALU_SrcA    = 1'b1;
          ALU_Control = c_ALU_SUB;
          PC_Src      = 2'b01;
          Branch      = (Op == c_OP_BEQ);
          Branch_NE   = (Op == c_OP_BNE);
        end
        c_S_JUMP: begin
          PC_Src   = 2'b10;
          PC_Write = 1'b1;
        end
        c_S_MEM_ADDR: begin
          ALU_SrcA    = 1'b1;
          ALU_SrcB    = 2'b10;
          ALU_Control = c_ALU_ADD;
        end
        c_S_MEM_RD: begin
          IorD = 1'b1;
        end
        c_S_MEM_WB: begin
          Reg_Write = 1'b1;
          Mem_Reg   = 1'b1;
        end
        c_S_MEM_WR: begin
          IorD      = 1'b1;
          Mem_Write = !w_timeout;
        end
        default: begin
        end
      endcase
    end
  end

  assign illegal_op = r_illegal;
  assign bus_err    = r_bus_err;
  assign state_dbg  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl_fsm
// Purpose  : Directed self-checking bench for multicycle_ctrl_fsm with
//            default parameters (ALUC_W=3, MEM_WAIT=1, WAIT_MAX=15,
//            TRAP_ILL=1). Inputs change 1 ns after the rising edge; outputs
//            are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       IorD, Mem_Write, IR_Write, PC_Write, Branch, Branch_NE;
  logic       ALU_SrcA, Reg_Write, Mem_Reg, Reg_Dst, en_zero_sign;
  logic [1:0] PC_Src, ALU_SrcB;
  logic [2:0] ALU_Control;
  logic       illegal_op, bus_err;
  logic [3:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(
    .ALUC_W  (3),
    .MEM_WAIT(1),
    .WAIT_MAX(15),
    .TRAP_ILL(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Op          (Op),
    .Funct       (Funct),
    .mem_ready   (mem_ready),
    .IorD        (IorD),
    .Mem_Write   (Mem_Write),
    .IR_Write    (IR_Write),
    .PC_Write    (PC_Write),
    .Branch      (Branch),
    .Branch_NE   (Branch_NE),
    .ALU_SrcA    (ALU_SrcA),
    .Reg_Write   (Reg_Write),
    .Mem_Reg     (Mem_Reg),
    .Reg_Dst     (Reg_Dst),
    .en_zero_sign(en_zero_sign),
    .PC_Src      (PC_Src),
    .ALU_SrcB    (ALU_SrcB),
    .ALU_Control (ALU_Control),
    .illegal_op  (illegal_op),
    .bus_err     (bus_err),
    .state_dbg   (state_dbg)
  );

  // Packed control word:
  // {IorD,Mem_Write,IR_Write,PC_Write,Branch,Branch_NE,ALU_SrcA,Reg_Write,
  //  Mem_Reg,Reg_Dst,en_zero_sign, PC_Src[1:0], ALU_SrcB[1:0], ALU_Control[2:0]}
  logic [17:0] ctl;
  assign ctl = {IorD, Mem_Write, IR_Write, PC_Write, Branch, Branch_NE, ALU_SrcA,
                Reg_Write, Mem_Reg, Reg_Dst, en_zero_sign, PC_Src, ALU_SrcB, ALU_Control};

  localparam logic [17:0] E_FR    = {11'b00110000000, 2'b00, 2'b01, 3'd1}; // FETCH, ready
  localparam logic [17:0] E_FW    = {11'b00000000000, 2'b00, 2'b01, 3'd1}; // FETCH, waiting
  localparam logic [17:0] E_DEC   = {11'b00000000000, 2'b00, 2'b11, 3'd1};
  localparam logic [17:0] E_EXR   = {11'b00000010000, 2'b00, 2'b00, 3'd1}; // add
  localparam logic [17:0] E_WBR   = {11'b00000001010, 2'b00, 2'b00, 3'd0};
  localparam logic [17:0] E_ORI   = {11'b00000010001, 2'b00, 2'b10, 3'd3};
  localparam logic [17:0] E_WBI   = {11'b00000001001, 2'b00, 2'b00, 3'd0}; // ori writeback
  localparam logic [17:0] E_MADDR = {11'b00000010000, 2'b00, 2'b10, 3'd1};
  localparam logic [17:0] E_MRD   = {11'b10000000000, 2'b00, 2'b00, 3'd0};
  localparam logic [17:0] E_MWB   = {11'b00000001100, 2'b00, 2'b00, 3'd0};
  localparam logic [17:0] E_MWR   = {11'b11000000000, 2'b00, 2'b00, 3'd0};
  localparam logic [17:0] E_BNE   = {11'b00000110000, 2'b01, 2'b00, 3'd4};
  localparam logic [17:0] E_BEQ   = {11'b00001010000, 2'b01, 2'b00, 3'd4};
  localparam logic [17:0] E_JMP   = {11'b00010000000, 2'b10, 2'b00, 3'd0};

  // Leaves the DUT in FETCH, 1 ns after the edge, with rst released
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; Op = 6'h00; Funct = 6'h20;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (ctl !== 18'd0) begin
      failures++;
      $display("FAIL reset_ctl: ctl=%h expected=%h", ctl, 18'd0);
    end
    checks++;
    if (state_dbg !== 4'd0 || illegal_op !== 1'b0 || bus_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: state=%0d ill=%b berr=%b expected state=0 ill=0 berr=0",
               state_dbg, illegal_op, bus_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== E_FR) begin
      failures++;
      $display("FAIL reset_release_fetch: ctl=%h expected=%h", ctl, E_FR);
    end
  endtask

  task automatic test_add();
    logic [3:0]  st [5];
    logic [17:0] ec [5];
    st = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd0};
    ec = '{E_FR, E_DEC, E_EXR, E_WBR, E_FR};
    do_reset();
    Op = 6'h00; Funct = 6'h20; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (state_dbg !== st[i] || ctl !== ec[i]) begin
        failures++;
        $display("FAIL add_step%0d: state=%0d ctl=%h expected state=%0d ctl=%h",
                 i, state_dbg, ctl, st[i], ec[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype_ops();
    logic [5:0] fn  [4];
    logic [2:0] alu [4];
    fn  = '{6'h22, 6'h24, 6'h25, 6'h2A};
    alu = '{3'd4, 3'd2, 3'd3, 3'd5};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      Op = 6'h00; Funct = fn[k]; mem_ready = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (state_dbg !== 4'd2 || ALU_Control !== alu[k] || ALU_SrcA !== 1'b1 ||
          ALU_SrcB !== 2'b00) begin
        failures++;
        $display("FAIL rtype_funct_%h: state=%0d alu=%0d srca=%b srcb=%b expected state=2 alu=%0d srca=1 srcb=00",
                 fn[k], state_dbg, ALU_Control, ALU_SrcA, ALU_SrcB, alu[k]);
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0]  st [9];
    logic [17:0] ec [9];
    logic        rd [9];
    st = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd8, 4'd8, 4'd8, 4'd9, 4'd0};
    ec = '{E_FR, E_DEC, E_MADDR, E_MRD, E_MRD, E_MRD, E_MRD, E_MWB, E_FR};
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    Op = 6'h23; Funct = 6'h00;
    for (int i = 0; i < 9; i++) begin
      mem_ready = rd[i];
      @(negedge clk);
      checks++;
      if (state_dbg !== st[i] || ctl !== ec[i]) begin
        failures++;
        $display("FAIL lw_step%0d: state=%0d ctl=%h expected state=%0d ctl=%h",
                 i, state_dbg, ctl, st[i], ec[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // bne followed directly by beq
  task automatic test_branch();
    logic [3:0]  st [7];
    logic [17:0] ec [7];
    logic [5:0]  op [7];
    st = '{4'd0, 4'd1, 4'd5, 4'd0, 4'd1, 4'd5, 4'd0};
    ec = '{E_FR, E_DEC, E_BNE, E_FR, E_DEC, E_BEQ, E_FR};
    op = '{6'h05, 6'h05, 6'h05, 6'h04, 6'h04, 6'h04, 6'h04};
    do_reset();
    mem_ready = 1'b1; Funct = 6'h00;
    for (int i = 0; i < 7; i++) begin
      Op = op[i];
      @(negedge clk);
      checks++;
      if (state_dbg !== st[i] || ctl !== ec[i]) begin
        failures++;
        $display("FAIL branch_step%0d: state=%0d ctl=%h expected state=%0d ctl=%h",
                 i, state_dbg, ctl, st[i], ec[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // sw with one wait cycle, then ori, then j
  task automatic test_back_to_back();
    logic [3:0]  st [13];
    logic [17:0] ec [13];
    logic [5:0]  op [13];
    logic        rd [13];
    st = '{4'd0, 4'd1, 4'd7, 4'd10, 4'd10, 4'd0, 4'd1, 4'd3, 4'd4, 4'd0, 4'd1, 4'd6, 4'd0};
    ec = '{E_FR, E_DEC, E_MADDR, E_MWR, E_MWR, E_FR, E_DEC, E_ORI, E_WBI,
           E_FR, E_DEC, E_JMP, E_FR};
    op = '{6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h0D, 6'h0D, 6'h0D, 6'h0D,
           6'h02, 6'h02, 6'h02, 6'h02};
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
           1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    Funct = 6'h00;
    for (int i = 0; i < 13; i++) begin
      Op = op[i]; mem_ready = rd[i];
      @(negedge clk);
      checks++;
      if (state_dbg !== st[i] || ctl !== ec[i]) begin
        failures++;
        $display("FAIL b2b_step%0d: state=%0d ctl=%h expected state=%0d ctl=%h",
                 i, state_dbg, ctl, st[i], ec[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    do_reset();
    Op = 6'h3F; Funct = 6'h00; mem_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (state_dbg !== 4'd15 || illegal_op !== 1'b1 || bus_err !== 1'b0 ||
          {Mem_Write, IR_Write, PC_Write, Reg_Write} !== 4'b0000) begin
        failures++;
        $display("FAIL trap_cycle%0d: state=%0d ill=%b berr=%b wr=%b expected state=15 ill=1 berr=0 wr=0000",
                 i, state_dbg, illegal_op, bus_err, {Mem_Write, IR_Write, PC_Write, Reg_Write});
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (state_dbg !== 4'd0 || illegal_op !== 1'b0 || ctl !== E_FR) begin
      failures++;
      $display("FAIL trap_reset: state=%0d ill=%b ctl=%h expected state=0 ill=0 ctl=%h",
               state_dbg, illegal_op, ctl, E_FR);
    end
    // Legal opcode with an unsupported function code also traps
    do_reset();
    Op = 6'h00; Funct = 6'h3F;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (state_dbg !== 4'd15 || illegal_op !== 1'b1) begin
      failures++;
      $display("FAIL bad_funct: state=%0d ill=%b expected state=15 ill=1", state_dbg, illegal_op);
    end
  endtask

  // 15 full wait cycles are tolerated; the 16th stalled cycle times out
  task automatic test_fetch_timeout();
    do_reset();
    Op = 6'h00; Funct = 6'h20; mem_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      checks++;
      if (i <= 15) begin
        if (state_dbg !== 4'd0 || bus_err !== 1'b0 || ctl !== E_FW) begin
          failures++;
          $display("FAIL fetch_wait%0d: state=%0d berr=%b ctl=%h expected state=0 berr=0 ctl=%h",
                   i, state_dbg, bus_err, ctl, E_FW);
        end
      end else begin
        if (state_dbg !== 4'd15 || bus_err !== 1'b1 || IR_Write !== 1'b0) begin
          failures++;
          $display("FAIL fetch_timeout: state=%0d berr=%b irw=%b expected state=15 berr=1 irw=0",
                   state_dbg, bus_err, IR_Write);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_timeout();
    do_reset();
    Op = 6'h2B; Funct = 6'h00; mem_ready = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    mem_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      checks++;
      if (i <= 14) begin
        if (state_dbg !== 4'd10 || Mem_Write !== 1'b1 || bus_err !== 1'b0) begin
          failures++;
          $display("FAIL sw_wait%0d: state=%0d memw=%b berr=%b expected state=10 memw=1 berr=0",
                   i, state_dbg, Mem_Write, bus_err);
        end
      end else if (i == 15) begin
        if (state_dbg !== 4'd10 || Mem_Write !== 1'b0) begin
          failures++;
          $display("FAIL sw_timeout_cycle: state=%0d memw=%b expected state=10 memw=0",
                   state_dbg, Mem_Write);
        end
      end else begin
        if (state_dbg !== 4'd15 || bus_err !== 1'b1) begin
          failures++;
          $display("FAIL sw_timeout_trap: state=%0d berr=%b expected state=15 berr=1",
                   state_dbg, bus_err);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    Op = 6'h2B; Funct = 6'h00; mem_ready = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state_dbg !== 4'd10 || Mem_Write !== 1'b1) begin
      failures++;
      $display("FAIL midwr_pre: state=%0d memw=%b expected state=10 memw=1", state_dbg, Mem_Write);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (Mem_Write !== 1'b0 || ctl !== 18'd0) begin
      failures++;
      $display("FAIL midwr_rst_same_cycle: memw=%b ctl=%h expected memw=0 ctl=0", Mem_Write, ctl);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (state_dbg !== 4'd0 || bus_err !== 1'b0) begin
      failures++;
      $display("FAIL midwr_next_state: state=%0d berr=%b expected state=0 berr=0", state_dbg, bus_err);
    end
    @(negedge clk);
    checks++;
    if (ctl !== E_FW) begin
      failures++;
      $display("FAIL midwr_fetch_ctl: ctl=%h expected=%h", ctl, E_FW);
    end
  endtask

  initial begin
    rst = 1'b1; Op = 6'h00; Funct = 6'h00; mem_ready = 1'b0;
    test_reset();
    test_add();
    test_rtype_ops();
    test_lw_wait();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_fetch_timeout();
    test_mem_timeout();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
